// File: rtl/rcpu_mem_bridge.sv
`default_nettype none
// ============================================================================
// Module   : rcpu_mem_bridge
// Purpose  : rcpu core <-> wait-stated external SRAM bridge with a posted-write
//            FIFO that drains ahead of every read. Optional one-entry read
//            buffer enabled by defining RCPU_MEMBRIDGE_RDBUF_EN.
// Revision : 1.0 - initial release
// ============================================================================
module rcpu_mem_bridge #(
    parameter int N        = 32,
    parameter int M        = 16,
    parameter int WAIT     = 2,
    parameter int WB_DEPTH = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] cpu_addr,
    input  logic [M-1:0] cpu_wdata,
    input  logic         cpu_re,
    input  logic         cpu_we,
    output logic [M-1:0] cpu_rdata,
    output logic         cpu_ready,
    output logic         wb_overflow,
    output logic [N-1:0] ext_addr,
    output logic [M-1:0] ext_wdata,
    input  logic [M-1:0] ext_rdata,
    output logic         ext_re,
    output logic         ext_we
);

    localparam int          PW      = (WB_DEPTH > 1) ? $clog2(WB_DEPTH) : 1;
    localparam logic [3:0]  WAIT_C  = 4'(WAIT);
    localparam logic [PW:0] DEPTH_C = (PW + 1)'(WB_DEPTH);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WR   = 2'd1,
        S_RD   = 2'd2,
        S_RESP = 2'd3
    } state_t;

    state_t        state_q, state_d;
    logic [3:0]    cnt_q, cnt_d;
    logic [N-1:0]  fifo_addr_q [WB_DEPTH];
    logic [M-1:0]  fifo_data_q [WB_DEPTH];
    logic [PW-1:0] wr_ptr_q, rd_ptr_q;
    logic [PW:0]   count_q;
    logic [N-1:0]  rd_addr_q, rd_addr_d;
    logic [M-1:0]  rdata_q, rdata_d;
    logic          ovf_q;
    logic          last_cyc, pop, push;

    // A full FIFO still takes a write on the edge its head retires.
    assign last_cyc = (cnt_q == WAIT_C);
    assign pop      = (state_q == S_WR) && last_cyc;
    assign push     = cpu_we && ((count_q != DEPTH_C) || pop);

    assign cpu_rdata   = rdata_q;
    assign wb_overflow = ovf_q;

`ifdef RCPU_MEMBRIDGE_RDBUF_EN
    logic         rb_valid_q, rb_valid_d;
    logic [N-1:0] rb_addr_q, rb_addr_d;
    logic [M-1:0] rb_data_q, rb_data_d;

    // Invalidation is applied after the fill so a same-edge write wins.
    always_comb begin
        rb_valid_d = rb_valid_q;
        rb_addr_d  = rb_addr_q;
        rb_data_d  = rb_data_q;
        if ((state_q == S_RD) && last_cyc) begin
            rb_valid_d = 1'b1;
            rb_addr_d  = rd_addr_q;
            rb_data_d  = ext_rdata;
        end
        if (push && (cpu_addr == rb_addr_d)) begin
            rb_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            rb_valid_q <= 1'b0;
            rb_addr_q  <= '0;
            rb_data_q  <= '0;
        end else begin
            rb_valid_q <= rb_valid_d;
            rb_addr_q  <= rb_addr_d;
            rb_data_q  <= rb_data_d;
        end
    end
`endif

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        rd_addr_d = rd_addr_q;
        rdata_d   = rdata_q;
        ext_re    = 1'b0;
        ext_we    = 1'b0;
        ext_addr  = '0;
        ext_wdata = '0;
        cpu_ready = 1'b0;
        case (state_q)
            S_IDLE: begin
                cnt_d = '0;
                // A read never launches alongside a write so it sees that write.
                if (count_q != '0) begin
                    state_d = S_WR;
                end else if (cpu_re && !cpu_we) begin
                    rd_addr_d = cpu_addr;
`ifdef RCPU_MEMBRIDGE_RDBUF_EN
                    if (rb_valid_q && (rb_addr_q == cpu_addr)) begin
                        rdata_d = rb_data_q;
                        state_d = S_RESP;
                    end else begin
                        state_d = S_RD;
                    end
`else
                    state_d = S_RD;
`endif
                end
            end
            S_WR: begin
                ext_we    = 1'b1;
                ext_addr  = fifo_addr_q[rd_ptr_q];
                ext_wdata = fifo_data_q[rd_ptr_q];
                if (last_cyc) begin
                    cnt_d   = '0;
                    state_d = S_IDLE;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            S_RD: begin
                ext_re   = 1'b1;
                ext_addr = rd_addr_q;
                if (last_cyc) begin
                    cnt_d   = '0;
                    rdata_d = ext_rdata;
                    state_d = S_RESP;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            S_RESP: begin
                cpu_ready = 1'b1;
                state_d   = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_addr_q[wr_ptr_q] <= cpu_addr;
            fifo_data_q[wr_ptr_q] <= cpu_wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            rd_addr_q <= '0;
            rdata_q   <= '0;
            ovf_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            rd_addr_q <= rd_addr_d;
            rdata_q   <= rdata_d;
            if (push) begin
                wr_ptr_q <= wr_ptr_q + PW'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PW'(1);
            end
            case ({push, pop})
                2'b10:   count_q <= count_q + (PW + 1)'(1);
                2'b01:   count_q <= count_q - (PW + 1)'(1);
                default: count_q <= count_q;
            endcase
            if (cpu_we && !push) begin
                ovf_q <= 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_rcpu_mem_bridge.sv
`default_nettype none
// ============================================================================
// Module   : tb_rcpu_mem_bridge
// Purpose  : Self-checking bench for rcpu_mem_bridge: directed scenarios plus
//            random read/write traffic against a flat memory reference.
//            Honours RCPU_MEMBRIDGE_RDBUF_EN when defined.
// Revision : 1.0 - initial release
// ============================================================================
module tb_rcpu_mem_bridge;

    localparam int WAIT     = 2;
    localparam int WB_DEPTH = 4;
`ifdef RCPU_MEMBRIDGE_RDBUF_EN
    localparam bit RDBUF = 1'b1;
`else
    localparam bit RDBUF = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [31:0] cpu_addr = '0, ext_addr;
    logic [15:0] cpu_wdata = '0, cpu_rdata, ext_wdata;
    logic [15:0] ext_rdata = '0;
    logic        cpu_re = 1'b0, cpu_we = 1'b0;
    logic        cpu_ready, wb_overflow, ext_re, ext_we;

    logic [31:0] cpu_addr0 = '0, ext_addr0;
    logic [15:0] cpu_rdata0, ext_wdata0, ext_rdata0;
    logic        cpu_re0 = 1'b0, cpu_ready0, wb_overflow0, ext_re0, ext_we0;

    always #5 clk = ~clk;

    rcpu_mem_bridge #(.N(32), .M(16), .WAIT(WAIT), .WB_DEPTH(WB_DEPTH)) dut (
        .clk(clk), .rst(rst), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_re(cpu_re), .cpu_we(cpu_we), .cpu_rdata(cpu_rdata), .cpu_ready(cpu_ready),
        .wb_overflow(wb_overflow), .ext_addr(ext_addr), .ext_wdata(ext_wdata),
        .ext_rdata(ext_rdata), .ext_re(ext_re), .ext_we(ext_we)
    );

    rcpu_mem_bridge #(.N(32), .M(16), .WAIT(0), .WB_DEPTH(WB_DEPTH)) dut0 (
        .clk(clk), .rst(rst), .cpu_addr(cpu_addr0), .cpu_wdata(16'h0),
        .cpu_re(cpu_re0), .cpu_we(1'b0), .cpu_rdata(cpu_rdata0), .cpu_ready(cpu_ready0),
        .wb_overflow(wb_overflow0), .ext_addr(ext_addr0), .ext_wdata(ext_wdata0),
        .ext_rdata(ext_rdata0), .ext_re(ext_re0), .ext_we(ext_we0)
    );

    assign ext_rdata0 = ext_re0 ? (ext_addr0[15:0] ^ 16'h1234) : 16'h0;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Reference memory sees CPU writes in program order; ext_mem is what the
    // external device actually received.
    logic [15:0] ref_mem [logic [31:0]];
    logic [15:0] ext_mem [logic [31:0]];
    logic [47:0] wlog[$];
    logic [47:0] exp_wlog[$];

    function automatic logic [15:0] init_val(input logic [31:0] a);
        return a[15:0] ^ 16'hA5C3;
    endfunction
    function automatic logic [15:0] ref_get(input logic [31:0] a);
        return ref_mem.exists(a) ? ref_mem[a] : init_val(a);
    endfunction
    function automatic logic [15:0] ext_get(input logic [31:0] a);
        return ext_mem.exists(a) ? ext_mem[a] : init_val(a);
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    int          we_run = 0, re_run = 0, rd_cnt = 0, viol = 0, last_re_start = 0, last_t0 = 0;
    logic [31:0] w_addr = '0, r_addr = '0;
    logic [15:0] w_data = '0;
    bit          skip_run = 1'b0, ready_prev = 1'b0;

    // External device model and protocol monitor; read data is only valid
    // in the final cycle of an access.
    always @(negedge clk) begin
        if (ext_we) begin
            if (we_run == 0) begin
                w_addr = ext_addr;
                w_data = ext_wdata;
            end else if (ext_addr !== w_addr || ext_wdata !== w_data) begin
                viol++;
            end
            we_run++;
        end else if (we_run != 0) begin
            if (!skip_run) begin
                if (we_run != WAIT + 1) viol++;
                ext_mem[w_addr] = w_data;
                wlog.push_back({w_addr, w_data});
            end
            we_run = 0;
        end
        if (ext_re) begin
            if (re_run == 0) begin
                r_addr = ext_addr;
                rd_cnt++;
                last_re_start = cyc;
            end else if (ext_addr !== r_addr) begin
                viol++;
            end
            re_run++;
        end else if (re_run != 0) begin
            if (!skip_run && re_run != WAIT + 1) viol++;
            re_run = 0;
        end
        ext_rdata = (ext_re && re_run == WAIT + 1) ? ext_get(ext_addr) : 16'($urandom);
        if (!ext_re && !ext_we && (ext_addr !== 32'h0 || ext_wdata !== 16'h0)) viol++;
        if (ext_re && ext_we) viol++;
        if (cpu_ready && ready_prev) viol++;
        ready_prev = cpu_ready;
    end

    task automatic cpu_write(input logic [31:0] a, input logic [15:0] d);
        @(negedge clk);
        cpu_we    = 1'b1;
        cpu_re    = 1'b0;
        cpu_addr  = a;
        cpu_wdata = d;
        ref_mem[a] = d;
        exp_wlog.push_back({a, d});
    endtask

    task automatic idle(input int n);
        @(negedge clk);
        cpu_we = 1'b0;
        cpu_re = 1'b0;
        repeat (n - 1) @(negedge clk);
    endtask

    task automatic cpu_read(input logic [31:0] a, input int exp_lat, input bit with_wr,
                            input logic [15:0] wd, input string tag);
        int t0, n;
        logic [15:0] exp;
        @(negedge clk);
        cpu_addr = a;
        cpu_re   = 1'b1;
        cpu_we   = with_wr;
        t0       = cyc;
        last_t0  = t0;
        if (with_wr) begin
            cpu_wdata = wd;
            ref_mem[a] = wd;
            exp_wlog.push_back({a, wd});
        end
        exp = ref_get(a);
        n = 0;
        do begin
            @(negedge clk);
            cpu_we = 1'b0;
            n++;
        end while (!cpu_ready && n < 200);
        cpu_re = 1'b0;
        chk({tag, "_ready"}, cpu_ready, 1);
        chk({tag, "_data"}, cpu_rdata, exp);
        if (exp_lat >= 0) chk({tag, "_lat"}, cyc - t0, exp_lat);
    endtask

    initial begin
        int t0, lat, wl0, r0, k, pulses;
        int rc[3];
        logic [15:0] d, got, exp16;

        repeat (3) @(negedge clk);
        chk("rst_ready", cpu_ready, 0);
        chk("rst_ext_re", ext_re, 0);
        chk("rst_ext_we", ext_we, 0);
        chk("rst_ext_addr", ext_addr, 0);
        chk("rst_rdata", cpu_rdata, 0);
        chk("rst_ovf", wb_overflow, 0);
        rst = 1'b1;
        @(negedge clk);

        // Single read: ext_re in cycles 1..WAIT+1, ready in cycle WAIT+2.
        ext_mem[32'h100] = 16'hBEEF;
        ref_mem[32'h100] = 16'hBEEF;
        r0 = rd_cnt;
        cpu_read(32'h100, WAIT + 2, 1'b0, 16'h0, "rd_beef");
        chk("rd_beef_re_start", last_re_start - last_t0, 1);
        chk("rd_beef_ext_reads", rd_cnt - r0, 1);

        // Two posted writes then a read; first WR begins in the request cycle.
        cpu_write(32'h10, 16'h1111);
        cpu_write(32'h11, 16'h2222);
        cpu_read(32'h10, 3 * (WAIT + 2) - 1, 1'b0, 16'h0, "raw");
        chk("raw_wlog_n", wlog.size(), 2);

        // Five writes while a read is in flight: fifth finds the FIFO full.
        @(negedge clk);
        cpu_addr = 32'h300;
        cpu_re   = 1'b1;
        cpu_we   = 1'b0;
        t0       = cyc;
        exp16    = ref_get(32'h300);
        lat      = -1;
        got      = 16'h0;
        wl0      = wlog.size();
        for (int i = 1; i <= 5; i++) begin
            @(negedge clk);
            if (cpu_ready) begin
                lat    = cyc - t0;
                got    = cpu_rdata;
                cpu_re = 1'b0;
            end
            d         = 16'($urandom);
            cpu_we    = 1'b1;
            cpu_addr  = 32'h40 + i;
            cpu_wdata = d;
            if (i < 5) begin
                ref_mem[32'h40 + i] = d;
                exp_wlog.push_back({32'h40 + i, d});
            end
        end
        idle(4 * (WAIT + 2) + 4);
        chk("ovf_rd_lat", lat, WAIT + 2);
        chk("ovf_rd_data", got, exp16);
        chk("ovf_flag", wb_overflow, 1);
        chk("ovf_ext_writes", wlog.size() - wl0, 4);
        cpu_read(32'h45, -1, 1'b0, 16'h0, "ovf_dropped");
        cpu_read(32'h44, -1, 1'b0, 16'h0, "ovf_kept");
        chk("ovf_sticky", wb_overflow, 1);

        // WAIT=0 back-to-back reads: ready every 3 cycles.
        rc = '{-1, -1, -1};
        k = 0;
        pulses = 0;
        @(negedge clk);
        cpu_addr0 = 32'h77;
        cpu_re0   = 1'b1;
        t0        = cyc;
        for (int i = 0; i < 14; i++) begin
            @(negedge clk);
            if (cpu_ready0) begin
                pulses++;
                if (k < 3) begin
                    rc[k] = cyc - t0;
                    k++;
                end
                if (k == 3) cpu_re0 = 1'b0;
                chk("w0_data", cpu_rdata0, 16'h0077 ^ 16'h1234);
            end
        end
        chk("w0_first", rc[0], 2);
        chk("w0_second", rc[1], 5);
        chk("w0_third", rc[2], 8);
        chk("w0_pulses", pulses, 3);

        // Reset asserted in cycle 2 of RD.
        @(negedge clk);
        cpu_addr = 32'h500;
        cpu_re   = 1'b1;
        @(negedge clk);
        @(negedge clk);
        skip_run = 1'b1;
        rst      = 1'b0;
        cpu_re   = 1'b0;
        @(negedge clk);
        chk("mid_rst_ext_re", ext_re, 0);
        chk("mid_rst_ext_we", ext_we, 0);
        chk("mid_rst_ready", cpu_ready, 0);
        chk("mid_rst_addr", ext_addr, 0);
        chk("mid_rst_rdata", cpu_rdata, 0);
        chk("mid_rst_ovf", wb_overflow, 0);
        rst = 1'b1;
        @(negedge clk);
        skip_run = 1'b0;
        cpu_read(32'h500, WAIT + 2, 1'b0, 16'h0, "post_rst");

        // Repeated read of one address, then a write to it.
        r0 = rd_cnt;
        cpu_read(32'h20, WAIT + 2, 1'b0, 16'h0, "rb_first");
        cpu_read(32'h20, RDBUF ? 1 : WAIT + 2, 1'b0, 16'h0, "rb_second");
        chk("rb_ext_reads", rd_cnt - r0, RDBUF ? 1 : 2);
        cpu_write(32'h20, 16'h5A01);
        cpu_read(32'h20, 2 * (WAIT + 2), 1'b0, 16'h0, "rb_after_wr");
        chk("rb_ext_reads2", rd_cnt - r0, RDBUF ? 2 : 3);

        // Simultaneous read and write to the same address returns new data.
        cpu_read(32'h21, -1, 1'b1, 16'hC0DE, "rw_same");

        // Random traffic over a small address window.
        for (int it = 0; it < 40; it++) begin
            int op;
            logic [31:0] a;
            op = $urandom_range(0, 2);
            a  = 32'h200 + $urandom_range(0, 7);
            if (op == 0) begin
                k = $urandom_range(1, 3);
                for (int j = 0; j < k; j++) begin
                    cpu_write(32'h200 + $urandom_range(0, 7), 16'($urandom));
                end
                idle(k * (WAIT + 2) + 1);
            end else if (op == 1) begin
                cpu_read(a, -1, 1'b0, 16'h0, $sformatf("rnd_rd%0d", it));
            end else begin
                cpu_read(a, -1, 1'b1, 16'($urandom), $sformatf("rnd_rw%0d", it));
            end
        end
        idle(30);

        chk("end_ovf", wb_overflow, 0);
        chk("end_monitor", viol, 0);
        chk("end_wlog_n", wlog.size(), exp_wlog.size());
        for (int i = 0; i < exp_wlog.size() && i < wlog.size(); i++) begin
            chk($sformatf("wlog%0d", i), wlog[i], exp_wlog[i]);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
